tenths_stopwatch: RTL and testbench
===================================

Name: tenths_stopwatch

Overview:
- Stopwatch core clocked from clk_100MHz and advanced by the 10 Hz square wave from the clock-divider stage.
- Counts tenths of a second in BCD, M:SS.t format, up to 9:59.9.
- Handles start/stop, clear and lap-hold commands.
- Drives BCD digits to the downstream seven-segment display multiplexer.

Parameters:
- MIN_MAX, 9, terminal value of the minutes digit (legal range 1–9)
- SEC_TENS_MAX, 5, terminal value of the seconds-tens digit

Ports:
- clk_100MHz  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- tick_10hz  input  1  10 Hz square wave from the divider; same clock domain; its rising edge is one count
- start_stop  input  1  single-cycle pulse (debounced upstream); toggles run/pause
- clear  input  1  single-cycle pulse; zeroes the count and returns to IDLE
- lap  input  1  single-cycle pulse; toggles display freeze
- digit_tenths  output  4  BCD tenths of a second, 0–9
- digit_sec_ones  output  4  BCD seconds units, 0–9
- digit_sec_tens  output  4  BCD seconds tens, 0–SEC_TENS_MAX
- digit_min  output  4  BCD minutes, 0–MIN_MAX
- running  output  1  high while in RUNNING
- lap_hold  output  1  high while the displayed digits are frozen
- wrapped  output  1  sticky; set when the count rolls over from max to zero

Behaviour:
- Reset: asynchronous, active-high. All of the following go to 0: state (IDLE), count digits, display digits, tick_prev, running, lap_hold, wrapped.
- Edge detect:
  - tick_prev register samples tick_10hz every cycle.
  - tick_edge = tick_10hz & ~tick_prev.
  - No synchroniser is used; the input is in the same clock domain.
- FSM states: IDLE, RUNNING, PAUSED.
  - IDLE --start_stop--> RUNNING
  - RUNNING --start_stop--> PAUSED
  - PAUSED --start_stop--> RUNNING
  - any state --clear--> IDLE
- running = (state == RUNNING), registered.
- Counting:
  - The count advances only when the current state is RUNNING and tick_edge is high.
  - The internal count updates on the clock edge following the cycle in which tick_edge is high (1-cycle latency).
  - Ripple order: tenths 9 -> 0 carries into sec_ones; sec_ones 9 -> 0 carries into sec_tens; sec_tens SEC_TENS_MAX -> 0 carries into min; min MIN_MAX -> 0 carries out.
  - The carry-out from min sets wrapped. Counting continues from 0:00.0.
- Display path:
  - lap_hold = 0: the display registers load the internal count every cycle, so digits lag the count by 1 cycle.
  - lap_hold = 1: the display registers hold their value while the internal count continues.
  - A lap pulse toggles lap_hold in RUNNING or PAUSED. In IDLE, lap is ignored.
- Simultaneous events:
  - clear has priority over everything. In the same cycle it zeroes the count and the display registers, and clears lap_hold and wrapped; the state goes to IDLE.
  - start_stop with tick_edge while in RUNNING: the tick is counted and the state moves to PAUSED.
  - start_stop with tick_edge while in IDLE or PAUSED: the tick is not counted.
  - start_stop and lap together: both take effect.
- Count integrity: in PAUSED the count never changes. No digit ever holds a non-BCD value or exceeds its terminal value.
- Reset mid-count: all outputs return to 0 immediately, asynchronously.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE = 2'd0, RUNNING = 2'd1, PAUSED = 2'd2.
  - BCD width constant (4).
  - Default terminal constants (9, 5).
- Sub-module bcd_digit_counter:
  - parameter MAX; inputs en and clr; outputs 4-bit q and carry.
  - carry = en & (q == MAX).
  - Instantiated four times in a ripple chain.

Test Plan:
1. Reset, then start_stop, then 25 tick rising edges -> digits read 0:02.5, running = 1, wrapped = 0.
2. Count to 0:59.9, then one further edge -> digits 1:00.0 (sec_tens carries into min at 5).
3. Pause at 0:01.3, apply 10 edges, then resume and apply 2 edges -> the value holds at 0:01.3 during pause; final value 0:01.5.
4. At 0:03.0 pulse lap, apply 20 edges, pulse lap again -> the display holds 0:03.0 throughout, then shows 0:05.0 one cycle after release; lap_hold goes 1 then 0.
5. Preset the count to 9:59.9 in RUNNING and apply one edge -> 0:00.0 and wrapped = 1. Then pulse clear -> wrapped = 0, state IDLE, all digits 0.
6. Simultaneous-event and reset checks:
   - clear coincident with tick_edge at 0:00.7 -> 0:00.0 next cycle and state IDLE.
   - start_stop coincident with tick_edge in RUNNING -> count +1 and PAUSED.
   - reset asserted mid-count -> all outputs 0 with no clock edge required.

Source files
------------

// File: rtl/tenths_stopwatch_pkg.sv
// Shared types and constants for the tenths-of-a-second stopwatch.
// State encoding is fixed so the display/debug side can decode it directly.
package tenths_stopwatch_pkg;

   localparam int BCD_W            = 4;
   localparam int DEF_TENTHS_MAX   = 9;
   localparam int DEF_SEC_ONES_MAX = 9;
   localparam int DEF_SEC_TENS_MAX = 5;
   localparam int DEF_MIN_MAX      = 9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2
   } state_t;

   function automatic logic [BCD_W-1:0] bcd_const(input int value);
      return BCD_W'(value);
   endfunction

endpackage

// File: rtl/tenths_stopwatch_bcd_digit_counter.sv
// One BCD digit of the ripple chain: counts 0..MAX while enabled and
// flags a carry in the cycle it rolls back to zero.
module bcd_digit_counter
   import tenths_stopwatch_pkg::*;
#(
   parameter int MAX = DEF_TENTHS_MAX
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   output logic [BCD_W-1:0] q,
   output logic             carry
);

   localparam logic [BCD_W-1:0] MAX_Q = bcd_const(MAX);

   assign carry = en & (q == MAX_Q);

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= (q == MAX_Q) ? '0 : q + BCD_W'(1);
      end
   end

endmodule

// File: rtl/tenths_stopwatch.sv
// Stopwatch core: M:SS.t BCD count advanced on rising edges of tick_10hz,
// with start/stop, clear and a lap-hold freeze on the display registers.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | count at zero, waiting for start_stop; lap ignored
// ST_RUNNING | count advances on each tick_10hz rising edge
// ST_PAUSED  | count frozen; start_stop resumes
module tenths_stopwatch
   import tenths_stopwatch_pkg::*;
#(
   parameter int MIN_MAX      = DEF_MIN_MAX,
   parameter int SEC_TENS_MAX = DEF_SEC_TENS_MAX
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             tick_10hz,
   input  logic             start_stop,
   input  logic             clear,
   input  logic             lap,
   output logic [BCD_W-1:0] digit_tenths,
   output logic [BCD_W-1:0] digit_sec_ones,
   output logic [BCD_W-1:0] digit_sec_tens,
   output logic [BCD_W-1:0] digit_min,
   output logic             running,
   output logic             lap_hold,
   output logic             wrapped
);

   state_t           state;
   logic             tick_prev;
   logic             tick_edge;
   logic             count_en;
   logic [BCD_W-1:0] cnt_tenths;
   logic [BCD_W-1:0] cnt_sec_ones;
   logic [BCD_W-1:0] cnt_sec_tens;
   logic [BCD_W-1:0] cnt_min;
   logic             carry_tenths;
   logic             carry_sec_ones;
   logic             carry_sec_tens;
   logic             carry_min;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         tick_prev <= 1'b0;
      end else begin
         tick_prev <= tick_10hz;
      end
   end

   assign tick_edge = tick_10hz & ~tick_prev;
   // Decided on the current state, so a tick arriving with start_stop is
   // counted only when leaving RUNNING.
   assign count_en  = (state == ST_RUNNING) & tick_edge & ~clear;

   bcd_digit_counter #(.MAX(DEF_TENTHS_MAX)) u_tenths (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .en         (count_en),
      .clr        (clear),
      .q          (cnt_tenths),
      .carry      (carry_tenths)
   );

   bcd_digit_counter #(.MAX(DEF_SEC_ONES_MAX)) u_sec_ones (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .en         (carry_tenths),
      .clr        (clear),
      .q          (cnt_sec_ones),
      .carry      (carry_sec_ones)
   );

   bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .en         (carry_sec_ones),
      .clr        (clear),
      .q          (cnt_sec_tens),
      .carry      (carry_sec_tens)
   );

   bcd_digit_counter #(.MAX(MIN_MAX)) u_min (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .en         (carry_sec_tens),
      .clr        (clear),
      .q          (cnt_min),
      .carry      (carry_min)
   );

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         running  <= 1'b0;
         lap_hold <= 1'b0;
         wrapped  <= 1'b0;
      end else if (clear) begin
         state    <= ST_IDLE;
         running  <= 1'b0;
         lap_hold <= 1'b0;
         wrapped  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_stop) begin
                  state   <= ST_RUNNING;
                  running <= 1'b1;
               end
            end
            ST_RUNNING: begin
               if (start_stop) begin
                  state   <= ST_PAUSED;
                  running <= 1'b0;
               end
            end
            ST_PAUSED: begin
               if (start_stop) begin
                  state   <= ST_RUNNING;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
            end
         endcase

         if (lap && (state != ST_IDLE)) begin
            lap_hold <= ~lap_hold;
         end

         if (carry_min) begin
            wrapped <= 1'b1;
         end
      end
   end

   // Display tracks the count one cycle late; lap_hold freezes it.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         digit_tenths   <= '0;
         digit_sec_ones <= '0;
         digit_sec_tens <= '0;
         digit_min      <= '0;
      end else if (clear) begin
         digit_tenths   <= '0;
         digit_sec_ones <= '0;
         digit_sec_tens <= '0;
         digit_min      <= '0;
      end else if (!lap_hold) begin
         digit_tenths   <= cnt_tenths;
         digit_sec_ones <= cnt_sec_ones;
         digit_sec_tens <= cnt_sec_tens;
         digit_min      <= cnt_min;
      end
   end

   a_tenths_range: assert property (@(posedge clk_100MHz) disable iff (reset)
      cnt_tenths <= bcd_const(DEF_TENTHS_MAX));
   a_sec_ones_range: assert property (@(posedge clk_100MHz) disable iff (reset)
      cnt_sec_ones <= bcd_const(DEF_SEC_ONES_MAX));
   a_sec_tens_range: assert property (@(posedge clk_100MHz) disable iff (reset)
      cnt_sec_tens <= bcd_const(SEC_TENS_MAX));
   a_min_range: assert property (@(posedge clk_100MHz) disable iff (reset)
      cnt_min <= bcd_const(MIN_MAX));
   a_paused_stable: assert property (@(posedge clk_100MHz) disable iff (reset)
      (state == ST_PAUSED && !clear) |=>
         $stable({cnt_min, cnt_sec_tens, cnt_sec_ones, cnt_tenths}));

endmodule

// File: tb/tb_tenths_stopwatch.sv
// Directed bench for tenths_stopwatch: stimulus pushes hand-computed
// expected outputs into a queue, a negedge monitor pops and compares them.
module tb_tenths_stopwatch;

   logic       clk_100MHz;
   logic       reset;
   logic       tick_10hz;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [3:0] digit_tenths;
   logic [3:0] digit_sec_ones;
   logic [3:0] digit_sec_tens;
   logic [3:0] digit_min;
   logic       running;
   logic       lap_hold;
   logic       wrapped;

   typedef struct {
      string       name;
      logic [18:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   tenths_stopwatch dut (
      .clk_100MHz     (clk_100MHz),
      .reset          (reset),
      .tick_10hz      (tick_10hz),
      .start_stop     (start_stop),
      .clear          (clear),
      .lap            (lap),
      .digit_tenths   (digit_tenths),
      .digit_sec_ones (digit_sec_ones),
      .digit_sec_tens (digit_sec_tens),
      .digit_min      (digit_min),
      .running        (running),
      .lap_hold       (lap_hold),
      .wrapped        (wrapped)
   );

   initial begin
      clk_100MHz = 1'b0;
      forever #5 clk_100MHz = ~clk_100MHz;
   end

   function automatic void push_exp(input string name, input int m, input int st,
                                    input int so, input int t, input bit run,
                                    input bit lh, input bit wr);
      exp_t e;
      e.name = name;
      e.v    = {4'(m), 4'(st), 4'(so), 4'(t), run, lh, wr};
      exp_q.push_back(e);
   endfunction

   // Monitor: samples between active edges, never drives stimulus.
   initial begin
      exp_t        e;
      logic [18:0] act;
      forever begin
         @(negedge clk_100MHz);
         while (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = {digit_min, digit_sec_tens, digit_sec_ones, digit_tenths,
                   running, lap_hold, wrapped};
            vectors++;
            if (act !== e.v) begin
               miscompares++;
               $display("FAIL %s: got %h:%h%h.%h run=%b lap=%b wrap=%b, want %h:%h%h.%h run=%b lap=%b wrap=%b",
                        e.name, act[18:15], act[14:11], act[10:7], act[6:3],
                        act[2], act[1], act[0],
                        e.v[18:15], e.v[14:11], e.v[10:7], e.v[6:3],
                        e.v[2], e.v[1], e.v[0]);
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk_100MHz);
      $display("FAIL watchdog: got no end of stimulus, want finish within 60000 cycles");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   task automatic step();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_10hz = 1'b1;
         step();
         tick_10hz = 1'b0;
         step();
      end
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      step();
      start_stop = 1'b0;
   endtask

   task automatic pulse_clr();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      step();
      lap = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      tick_10hz  = 1'b0;
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
      repeat (3) step();
      push_exp("reset_state", 0, 0, 0, 0, 0, 0, 0);
      step();
      reset = 1'b0;
      step();

      // 1: basic count to 0:02.5
      pulse_ss();
      push_exp("t1_start", 0, 0, 0, 0, 1, 0, 0);
      ticks(25);
      push_exp("t1_0025", 0, 0, 2, 5, 1, 0, 0);

      // 2: sec_tens carries into min at 5
      ticks(574);
      push_exp("t2_0599", 0, 5, 9, 9, 1, 0, 0);
      ticks(1);
      push_exp("t2_1000", 1, 0, 0, 0, 1, 0, 0);

      // 3: pause holds the count
      pulse_clr();
      push_exp("t3_clear", 0, 0, 0, 0, 0, 0, 0);
      pulse_ss();
      ticks(13);
      push_exp("t3_0013", 0, 0, 1, 3, 1, 0, 0);
      pulse_ss();
      push_exp("t3_pause", 0, 0, 1, 3, 0, 0, 0);
      ticks(10);
      push_exp("t3_hold", 0, 0, 1, 3, 0, 0, 0);
      pulse_ss();
      ticks(2);
      push_exp("t3_0015", 0, 0, 1, 5, 1, 0, 0);

      // 4: lap hold freezes the display only
      pulse_clr();
      pulse_ss();
      ticks(30);
      push_exp("t4_0030", 0, 0, 3, 0, 1, 0, 0);
      pulse_lap();
      push_exp("t4_lap_on", 0, 0, 3, 0, 1, 1, 0);
      ticks(10);
      push_exp("t4_mid", 0, 0, 3, 0, 1, 1, 0);
      ticks(10);
      push_exp("t4_end", 0, 0, 3, 0, 1, 1, 0);
      pulse_lap();
      push_exp("t4_release", 0, 0, 3, 0, 1, 0, 0);
      step();
      push_exp("t4_0050", 0, 0, 5, 0, 1, 0, 0);

      // 5: wrap from 9:59.9
      pulse_clr();
      pulse_ss();
      ticks(5999);
      push_exp("t5_max", 9, 5, 9, 9, 1, 0, 0);
      ticks(1);
      push_exp("t5_wrap", 0, 0, 0, 0, 1, 0, 1);
      ticks(1);
      push_exp("t5_continue", 0, 0, 0, 1, 1, 0, 1);
      pulse_clr();
      push_exp("t5_clear", 0, 0, 0, 0, 0, 0, 0);

      // 6a: clear coincident with a tick
      pulse_ss();
      ticks(7);
      push_exp("t6_0007", 0, 0, 0, 7, 1, 0, 0);
      tick_10hz = 1'b1;
      clear     = 1'b1;
      step();
      tick_10hz = 1'b0;
      clear     = 1'b0;
      push_exp("t6_clr_tick", 0, 0, 0, 0, 0, 0, 0);
      step();
      push_exp("t6_clr_after", 0, 0, 0, 0, 0, 0, 0);

      // 6b: start_stop coincident with a tick
      pulse_ss();
      ticks(4);
      push_exp("t6_0004", 0, 0, 0, 4, 1, 0, 0);
      tick_10hz  = 1'b1;
      start_stop = 1'b1;
      step();
      tick_10hz  = 1'b0;
      start_stop = 1'b0;
      push_exp("t6_ss_tick_state", 0, 0, 0, 4, 0, 0, 0);
      step();
      push_exp("t6_ss_tick_count", 0, 0, 0, 5, 0, 0, 0);
      ticks(3);
      push_exp("t6_paused", 0, 0, 0, 5, 0, 0, 0);
      tick_10hz  = 1'b1;
      start_stop = 1'b1;
      step();
      tick_10hz  = 1'b0;
      start_stop = 1'b0;
      step();
      push_exp("t6_resume_nocount", 0, 0, 0, 5, 1, 0, 0);
      ticks(1);
      push_exp("t6_0006", 0, 0, 0, 6, 1, 0, 0);

      // 6c: lap in IDLE, start_stop with lap
      pulse_clr();
      pulse_lap();
      push_exp("t6_lap_idle", 0, 0, 0, 0, 0, 0, 0);
      start_stop = 1'b1;
      lap        = 1'b1;
      step();
      start_stop = 1'b0;
      lap        = 1'b0;
      push_exp("t6_ss_lap_idle", 0, 0, 0, 0, 1, 0, 0);
      ticks(2);
      start_stop = 1'b1;
      lap        = 1'b1;
      step();
      start_stop = 1'b0;
      lap        = 1'b0;
      push_exp("t6_ss_lap_run", 0, 0, 0, 2, 0, 1, 0);

      // 6d: asynchronous reset mid-count
      pulse_ss();
      ticks(3);
      push_exp("t6_pre_reset", 0, 0, 0, 2, 1, 1, 0);
      step();
      reset = 1'b1;
      push_exp("t6_async_reset", 0, 0, 0, 0, 0, 0, 0);
      step();
      push_exp("t6_reset_held", 0, 0, 0, 0, 0, 0, 0);
      step();
      reset = 1'b0;
      step();
      ticks(2);
      push_exp("t6_idle_no_count", 0, 0, 0, 0, 0, 0, 0);

      repeat (4) step();
      if (exp_q.size() != 0) begin
         $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
